adc_spi_responder: RTL and testbench

- SPI mode-0 slave that acts as the far end of the ADC SPI master. It serves latched multi-channel ADC sample words on MISO and captures the command words the master sends on MOSI.
- Used as an in-fabric ADC stand-in for loopback and bring-up of the acquisition path. It is also the base for the SPI slave personality of the ADC front end.
- Sits between the sample source (capture or test-pattern logic) and the SPI pins. All SPI inputs are oversampled on the system clock.

---
 rtl/adc_spi_responder.sv | 159 +++++++++++++++
 tb/tb_adc_spi_responder.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_responder.sv
// SPI mode-0 slave standing in for the ADC: serves a latched multi-channel sample set on MISO
// and captures master command words on MOSI. All SPI pins are oversampled on clk.
module adc_spi_responder #(
  parameter int DATA_W      = 16,
  parameter int NUM_CH      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sample_valid,
  input  logic [NUM_CH*DATA_W-1:0] sample_data,
  input  logic                     spi_sclk,
  input  logic                     spi_ss_n,
  input  logic                     spi_mosi,
  output logic                     spi_miso,
  output logic                     spi_miso_oe,
  output logic [DATA_W-1:0]        rx_word,
  output logic                     rx_valid,
  output logic                     frame_done,
  output logic                     busy,
  output logic                     overrun
);

  localparam int BIT_W = $clog2(DATA_W);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  // Synchronizers, plus one extra registered copy of each synced level for edge detection.
  logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, ss_prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync_q <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], spi_ss_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      ss_prev_q   <= ss_sync_q[SYNC_STAGES-1];
    end
  end

  logic sclk_s, ss_s, mosi_s;
  logic sclk_rise, sclk_fall, ss_fall, ss_rise;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign ss_fall   = ~ss_s & ss_prev_q;
  assign ss_rise   = ss_s & ~ss_prev_q;

  state_t                   state_q;
  logic [NUM_CH*DATA_W-1:0] buf_q, pend_q;
  logic                     pend_flag_q;
  logic [DATA_W-1:0]        tx_q;
  logic [DATA_W-2:0]        rx_shift_q;
  logic [BIT_W-1:0]         bit_cnt_q;
  logic [CH_W-1:0]          ch_cnt_q;
  logic [DATA_W-1:0]        rx_word_q;
  logic                     rx_valid_q, frame_done_q, oe_q, overrun_q;

  logic [DATA_W-1:0] cur_word;
  assign cur_word = buf_q[int'(ch_cnt_q)*DATA_W +: DATA_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      buf_q        <= '0;
      pend_q       <= '0;
      pend_flag_q  <= 1'b0;
      tx_q         <= '0;
      rx_shift_q   <= '0;
      bit_cnt_q    <= '0;
      ch_cnt_q     <= '0;
      rx_word_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
      oe_q         <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rx_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;

      // The served buffer only changes outside a frame; mid-frame samples park in pending.
      if (sample_valid) begin
        if (state_q == IDLE && !ss_fall) begin
          buf_q <= sample_data;
        end else if (state_q == SHIFT && ss_rise) begin
          buf_q       <= sample_data;
          pend_flag_q <= 1'b0;
          if (pend_flag_q) overrun_q <= 1'b1;
        end else begin
          pend_q      <= sample_data;
          pend_flag_q <= 1'b1;
          if (pend_flag_q) overrun_q <= 1'b1;
        end
      end else if (state_q == SHIFT && ss_rise && pend_flag_q) begin
        buf_q       <= pend_q;
        pend_flag_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (ss_fall) begin
            state_q   <= SHIFT;
            tx_q      <= buf_q[DATA_W-1:0];
            oe_q      <= 1'b1;
            bit_cnt_q <= '0;
            ch_cnt_q  <= '0;
          end
        end
        SHIFT: begin
          // Deselect wins over any SCLK edge seen in the same cycle.
          if (ss_rise) begin
            state_q      <= IDLE;
            frame_done_q <= 1'b1;
            oe_q         <= 1'b0;
            tx_q         <= '0;
            bit_cnt_q    <= '0;
            ch_cnt_q     <= '0;
          end else if (sclk_rise) begin
            rx_shift_q <= {rx_shift_q[DATA_W-3:0], mosi_s};
            if (bit_cnt_q == LAST_BIT) begin
              rx_word_q  <= {rx_shift_q, mosi_s};
              rx_valid_q <= 1'b1;
              bit_cnt_q  <= '0;
              ch_cnt_q   <= (ch_cnt_q == LAST_CH) ? '0 : ch_cnt_q + CH_W'(1);
            end else begin
              bit_cnt_q <= bit_cnt_q + BIT_W'(1);
            end
          end else if (sclk_fall) begin
            if (bit_cnt_q != '0) tx_q <= {tx_q[DATA_W-2:0], 1'b0};
            else                 tx_q <= cur_word;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign spi_miso    = tx_q[DATA_W-1];
  assign spi_miso_oe = oe_q;
  assign rx_word     = rx_word_q;
  assign rx_valid    = rx_valid_q;
  assign frame_done  = frame_done_q;
  assign busy        = (state_q == SHIFT);
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Bench for adc_spi_responder: drives SPI frames at clk/8 and checks MISO words, received
// words, pulses and overrun against a frame-level sample-buffer model.
module tb_adc_spi_responder;
  localparam int DW  = 16;
  localparam int NCH = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              sample_valid;
  logic [NCH*DW-1:0] sample_data;
  logic              spi_sclk, spi_ss_n, spi_mosi;
  logic              spi_miso, spi_miso_oe;
  logic [DW-1:0]     rx_word;
  logic              rx_valid, frame_done, busy, overrun;

  always #5 clk = ~clk;

  adc_spi_responder #(.DATA_W(DW), .NUM_CH(NCH), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_data(sample_data),
    .spi_sclk(spi_sclk), .spi_ss_n(spi_ss_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .rx_word(rx_word),
    .rx_valid(rx_valid), .frame_done(frame_done), .busy(busy), .overrun(overrun)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: served sample set, pending set, overrun flag.
  logic [NCH*DW-1:0] model_buf, model_pend;
  bit                model_pend_f, model_ovr;

  logic [DW-1:0]     mosi_q[$];
  logic [DW-1:0]     miso_q[$];
  logic [DW-1:0]     rx_q[$];
  logic [DW-1:0]     exp_q[$];
  logic [NCH*DW-1:0] mid_data[2];
  int                fd_cnt;
  bit                fd_seen;
  logic              fd_oe, fd_miso, busy_seen, oe_seen;

  function automatic void model_sample(input logic [NCH*DW-1:0] d, input bit in_frame);
    if (!in_frame) model_buf = d;
    else begin
      if (model_pend_f) model_ovr = 1'b1;
      model_pend   = d;
      model_pend_f = 1'b1;
    end
  endfunction

  function automatic void model_frame_end();
    if (model_pend_f) begin
      model_buf    = model_pend;
      model_pend_f = 1'b0;
    end
  endfunction

  function automatic void build_exp(input int nbits);
    exp_q.delete();
    for (int k = 0; k < nbits / DW; k++) exp_q.push_back(model_buf[(k % NCH)*DW +: DW]);
  endfunction

  function automatic logic [NCH*DW-1:0] ramp_set(input logic [DW-1:0] base);
    logic [NCH*DW-1:0] s;
    for (int c = 0; c < NCH; c++) s[c*DW +: DW] = base + DW'(c);
    return s;
  endfunction

  function automatic logic [NCH*DW-1:0] rand_set();
    logic [NCH*DW-1:0] s;
    for (int c = 0; c < NCH; c++) s[c*DW +: DW] = DW'($urandom_range(0, 65535));
    return s;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid) rx_q.push_back(rx_word);
      if (frame_done) fd_cnt++;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, required finish before 3ms");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_idle(input logic [NCH*DW-1:0] d);
    sample_data  = d;
    sample_valid = 1'b1;
    tick(1);
    sample_valid = 1'b0;
    model_sample(d, 1'b0);
  endtask

  task automatic pulse_sample(input logic [NCH*DW-1:0] d);
    sample_data  = d;
    sample_valid = 1'b1;
    tick(1);
    sample_valid = 1'b0;
    model_sample(d, 1'b1);
  endtask

  task automatic fill_mosi(input int nwords, input bit fixed);
    mosi_q.delete();
    for (int k = 0; k < nwords; k++)
      mosi_q.push_back(fixed ? 16'hA5C3 : DW'($urandom_range(0, 65535)));
  endtask

  // Master side of one frame; abort_at >= 0 asserts reset in the low phase of that bit.
  task automatic run_frame(input int nbits, input int abort_at, input int n_mid);
    logic [DW-1:0] cur, w;
    cur = '0;
    miso_q.delete(); rx_q.delete(); fd_cnt = 0; fd_seen = 1'b0;
    spi_ss_n = 1'b0;
    tick(8);
    busy_seen = busy;
    oe_seen   = spi_miso_oe;
    for (int i = 0; i < nbits; i++) begin
      w = mosi_q[i / DW];
      spi_mosi = w[DW-1-(i % DW)];
      if (n_mid > 0 && i == 5)  pulse_sample(mid_data[0]);
      if (n_mid > 1 && i == 40) pulse_sample(mid_data[1]);
      if (i == abort_at) begin
        reset = 1'b1;
        tick(1);
        return;
      end
      tick(4);
      cur = {cur[DW-2:0], spi_miso};
      if (i % DW == DW-1) miso_q.push_back(cur);
      spi_sclk = 1'b1;
      tick(4);
      spi_sclk = 1'b0;
    end
    tick(4);
    spi_ss_n = 1'b1;
    for (int k = 0; k < 12 && !fd_seen; k++) begin
      tick(1);
      if (frame_done) begin
        fd_seen = 1'b1;
        fd_oe   = spi_miso_oe;
        fd_miso = spi_miso;
      end
    end
    if (!fd_seen) begin
      n_vec++; n_err++;
      $display("FAIL frame_done_timeout: no pulse within 12 cycles, required 1");
    end
    tick(4);
    model_frame_end();
  endtask

  task automatic test_reset();
    reset = 1'b1; sample_valid = 1'b0; sample_data = '0;
    spi_sclk = 1'b0; spi_ss_n = 1'b1; spi_mosi = 1'b0;
    model_buf = '0; model_pend = '0; model_pend_f = 1'b0; model_ovr = 1'b0;
    tick(3);
    n_vec++;
    if ({spi_miso, spi_miso_oe, rx_valid, frame_done, busy, overrun} !== 6'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b required 000000",
        {spi_miso, spi_miso_oe, rx_valid, frame_done, busy, overrun});
    end
    n_vec++;
    if (rx_word !== 16'h0) begin n_err++; $display("FAIL reset_rx_word: got %h required 0000", rx_word); end
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_basic_frame();
    load_idle(ramp_set(16'h1000));
    fill_mosi(8, 1'b1);
    build_exp(128);
    run_frame(128, -1, 0);
    n_vec++;
    if ({busy_seen, oe_seen} !== 2'b11) begin n_err++; $display("FAIL basic_busy_oe: got %b required 11", {busy_seen, oe_seen}); end
    for (int k = 0; k < 8; k++) begin
      n_vec++;
      if (miso_q[k] !== 16'h1000 + DW'(k)) begin n_err++; $display("FAIL basic_miso[%0d]: got %h required %h", k, miso_q[k], 16'h1000 + DW'(k)); end
    end
    n_vec++;
    if (rx_q.size() != 8) begin n_err++; $display("FAIL basic_rx_count: got %0d required 8", rx_q.size()); end
    for (int k = 0; k < rx_q.size(); k++) begin
      n_vec++;
      if (rx_q[k] !== 16'hA5C3) begin n_err++; $display("FAIL basic_rx[%0d]: got %h required a5c3", k, rx_q[k]); end
    end
    n_vec++;
    if (fd_cnt != 1) begin n_err++; $display("FAIL basic_frame_done: got %0d required 1", fd_cnt); end
    n_vec++;
    if ({fd_oe, fd_miso} !== 2'b00) begin n_err++; $display("FAIL basic_end_oe: got %b required 00", {fd_oe, fd_miso}); end
  endtask

  task automatic test_channel_wrap();
    fill_mosi(10, 1'b0);
    build_exp(160);
    run_frame(160, -1, 0);
    n_vec++;
    if (miso_q[8] !== 16'h1000 || miso_q[9] !== 16'h1001) begin
      n_err++; $display("FAIL wrap_miso: got %h %h required 1000 1001", miso_q[8], miso_q[9]);
    end
    n_vec++;
    if (rx_q.size() != 10) begin n_err++; $display("FAIL wrap_rx_count: got %0d required 10", rx_q.size()); end
    for (int k = 0; k < rx_q.size(); k++) begin
      n_vec++;
      if (rx_q[k] !== mosi_q[k]) begin n_err++; $display("FAIL wrap_rx[%0d]: got %h required %h", k, rx_q[k], mosi_q[k]); end
    end
  endtask

  task automatic test_partial_frame();
    fill_mosi(2, 1'b0);
    run_frame(20, -1, 0);
    n_vec++;
    if (rx_q.size() != 1 || rx_q[0] !== mosi_q[0]) begin
      n_err++; $display("FAIL partial_rx: got count %0d required 1 word %h", rx_q.size(), mosi_q[0]);
    end
    n_vec++;
    if (fd_cnt != 1 || fd_oe !== 1'b0) begin n_err++; $display("FAIL partial_end: got fd %0d oe %b required 1 0", fd_cnt, fd_oe); end
    fill_mosi(2, 1'b0);
    run_frame(32, -1, 0);
    n_vec++;
    if (miso_q[0] !== 16'h1000 || miso_q[1] !== 16'h1001) begin
      n_err++; $display("FAIL partial_restart: got %h %h required 1000 1001", miso_q[0], miso_q[1]);
    end
  endtask

  task automatic test_mid_frame_sample();
    mid_data[0] = {NCH{16'hBEEF}};
    for (int f = 0; f < 2; f++) begin
      fill_mosi(8, 1'b0);
      build_exp(128);
      run_frame(128, -1, (f == 0) ? 1 : 0);
      for (int k = 0; k < 8; k++) begin
        n_vec++;
        if (miso_q[k] !== ((f == 0) ? 16'h1000 + DW'(k) : 16'hBEEF)) begin
          n_err++; $display("FAIL mid_miso f%0d[%0d]: got %h required %h", f, k, miso_q[k],
            (f == 0) ? 16'h1000 + DW'(k) : 16'hBEEF);
        end
      end
      n_vec++;
      if (overrun !== 1'b0) begin n_err++; $display("FAIL mid_overrun: got %b required 0", overrun); end
    end
  endtask

  task automatic test_overrun();
    mid_data[0] = rand_set();
    mid_data[1] = rand_set();
    for (int f = 0; f < 3; f++) begin
      fill_mosi(8, 1'b0);
      build_exp(128);
      run_frame(128, -1, (f == 0) ? 2 : 0);
      for (int k = 0; k < 8; k++) begin
        n_vec++;
        if (miso_q[k] !== exp_q[k]) begin n_err++; $display("FAIL ovr_miso f%0d[%0d]: got %h required %h", f, k, miso_q[k], exp_q[k]); end
      end
      if (f == 1) begin
        n_vec++;
        if (exp_q[3] !== mid_data[1][3*DW +: DW]) begin
          n_err++; $display("FAIL ovr_model_second_set: got %h required %h", exp_q[3], mid_data[1][3*DW +: DW]);
        end
      end
      n_vec++;
      if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_sticky f%0d: got %b required 1", f, overrun); end
    end
  endtask

  task automatic test_random_frames();
    int nbits, nmid;
    for (int r = 0; r < 5; r++) begin
      if ($urandom_range(0, 1) == 1) load_idle(rand_set());
      nbits = $urandom_range(17, 200);
      nmid  = $urandom_range(0, 1);
      mid_data[0] = rand_set();
      fill_mosi((nbits + DW - 1) / DW, 1'b0);
      build_exp(nbits);
      run_frame(nbits, -1, nmid);
      for (int k = 0; k < exp_q.size(); k++) begin
        n_vec++;
        if (miso_q[k] !== exp_q[k]) begin n_err++; $display("FAIL rand%0d_miso[%0d]: got %h required %h", r, k, miso_q[k], exp_q[k]); end
      end
      n_vec++;
      if (rx_q.size() != nbits / DW) begin n_err++; $display("FAIL rand%0d_rx_count: got %0d required %0d", r, rx_q.size(), nbits / DW); end
      for (int k = 0; k < rx_q.size(); k++) begin
        n_vec++;
        if (rx_q[k] !== mosi_q[k]) begin n_err++; $display("FAIL rand%0d_rx[%0d]: got %h required %h", r, k, rx_q[k], mosi_q[k]); end
      end
      n_vec++;
      if (overrun !== model_ovr) begin n_err++; $display("FAIL rand%0d_overrun: got %b required %b", r, overrun, model_ovr); end
    end
  endtask

  task automatic test_reset_mid_frame();
    load_idle(ramp_set(16'h1000));
    fill_mosi(8, 1'b0);
    run_frame(128, 3*DW + 7, 0);
    n_vec++;
    if ({spi_miso, spi_miso_oe, rx_valid, frame_done, busy, overrun} !== 6'b0 || rx_word !== 16'h0) begin
      n_err++; $display("FAIL abort_outputs: got %b rx_word %h required all zero",
        {spi_miso, spi_miso_oe, rx_valid, frame_done, busy, overrun}, rx_word);
    end
    n_vec++;
    if (rx_q.size() != 3) begin n_err++; $display("FAIL abort_pre_words: got %0d required 3", rx_q.size()); end
    spi_ss_n = 1'b1; spi_sclk = 1'b0;
    model_buf = '0; model_pend_f = 1'b0; model_ovr = 1'b0;
    tick(2);
    rx_q.delete(); fd_cnt = 0;
    reset = 1'b0;
    tick(20);
    n_vec++;
    if (rx_q.size() != 0 || fd_cnt != 0 || busy !== 1'b0) begin
      n_err++; $display("FAIL abort_no_pulses: got rx %0d fd %0d busy %b required 0 0 0", rx_q.size(), fd_cnt, busy);
    end
    fill_mosi(8, 1'b0);
    run_frame(128, -1, 0);
    for (int k = 0; k < 8; k++) begin
      n_vec++;
      if (miso_q[k] !== 16'h0) begin n_err++; $display("FAIL abort_zero_miso[%0d]: got %h required 0000", k, miso_q[k]); end
    end
    n_vec++;
    if (overrun !== 1'b0) begin n_err++; $display("FAIL abort_overrun: got %b required 0", overrun); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_channel_wrap();
    test_partial_frame();
    test_mid_frame_sample();
    test_overrun();
    test_random_frames();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
